lsu_mem_if: RTL
===============

// Module: lsu_mem_if
// PURPOSE
//   Load/store bridge between the lanzones core's data-access port and the word-addressed RRdy/RVld memory bus.
//   - Converts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word address, byte strobes and lane-shifted data.
//   - Returns sign- or zero-extended load data, with a response timeout.
//   - Sits directly upstream of the memory model; one request in flight.
// PARAMETERS
//   TIMEOUT_CYC  16  max BUS-state cycles waiting for RVld before an error response (>=2)
//   CNT_W        5   timeout counter width; must hold TIMEOUT_CYC
// PORTS
//   clk        in   1   clock; one clock; reset is synchronous and active-high
//   rst        in   1   reset; one clock; reset is synchronous and active-high
//   ReqVld     in   1   core request valid
//   ReqRdy     out  1   bridge can accept a request (state IDLE)
//   ReqWr      in   1   1=store, 0=load
//   ReqSize    in   3   RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   ReqAddr    in   32  byte address
//   ReqWData   in   32  store data, right-aligned
//   RspVld     out  1   one-cycle response pulse (loads and stores)
//   RspData    out  32  extended load data; 0 for stores and errors
//   RspErr     out  1   timeout, illegal size or trapped misalignment; qualified by RspVld
//   RRdy       out  1   memory request strobe
//   RVld       in   1   memory acknowledge; RData valid in the same cycle
//   RAddr      out  32  word address = ReqAddr[31:2]
//   RWData     out  32  lane-replicated store data
//   RWEn       out  1   write enable, high for exactly one cycle per store
//   RWStrobe   out  4   byte-lane enables
//   RData      in   32  memory read word
// BEHAVIOUR
//   - Reset values: all outputs 0 except ReqRdy=1; state IDLE; counter 0.
//   - Reset mid-access abandons the access: no RspVld, and RWEn/RRdy are low from the next cycle.
//   - Accept: ReqVld & ReqRdy latches ReqWr, ReqSize, ReqAddr and ReqWData.
//     - ReqRdy is combinational: ReqRdy = (state==IDLE).
//   - FSM: IDLE -> BUS on accept; IDLE -> RESP on accept of an error request (no bus activity).
//     - BUS -> RESP on RVld, or when the counter reaches TIMEOUT_CYC-1 without RVld.
//     - RESP -> IDLE after one cycle.
//   - BUS: RRdy=1 every cycle; RWEn=ReqWr in the first BUS cycle only; counter increments each BUS cycle.
//     - RAddr, RWData and RWStrobe are held stable throughout BUS.
//     - RWData and RWStrobe are driven 0 for loads.
//     - RVld in the first BUS cycle is ignored; accepted from the second onward.
//   - Minimum latency, accept to RspVld: 3 cycles (accept, BUS x2, RESP).
//   - Strobes:
//     - SB: 4'b0001<<A[1:0], RWData={4{d[7:0]}}
//     - SH: 4'b0011<<{A[1],1'b0}, RWData={2{d[15:0]}}
//     - SW: 4'b1111, RWData=d
//   - Loads: RData captured on RVld, shifted right by 8*A[1:0].
//     - B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes the word.
//   - Illegal ReqSize: 011, 110, 111, or stores with 100/101.
//     - Response is RspVld with RspErr=1, RspData=0; no RRdy/RWEn.
//   - Timeout: RspErr=1, RspData=0, RRdy drops in the RESP cycle.
//     - A late RVld arriving in IDLE is ignored.
//   - ReqVld during BUS/RESP is not accepted.
//     - The core holds the request; accepting in the cycle after RspVld is legal.
// CONFIGURATION
//   MISALIGN_TRAP_EN defined:
//     - H with A[0]=1, or W with A[1:0]!=0, takes the error path: RspErr=1, no bus access.
//   MISALIGN_TRAP_EN undefined:
//     - Offending low bits are forced to 0 (H uses A[1]; W ignores A[1:0]).
//     - The access completes with RspErr=0.
// TESTING
//   - SW A=0x400 d=0xDEADBEEF -> RAddr=0x100, RWStrobe=4'hF, RWEn 1 cycle; mem[0x100]=0xDEADBEEF, RspErr=0.
//   - SB A=0x402 d=0x55 onto 0xDEADBEEF -> RWStrobe=4'b0100; mem=0xDE55BEEF; LB A=0x403 -> RspData=0xFFFFFFDE.
//   - LHU A=0x402 on word 0x8001_7FFF -> RspData=0x00008001; LH -> 0xFFFF8001; RspVld 3 cycles after accept.
//   - RVld tied low, LW -> RspErr=1, RspData=0 after TIMEOUT_CYC BUS cycles; next request is accepted normally.
//   - LW A=0x401:
//     - MISALIGN_TRAP_EN defined: RspErr=1 with no RRdy.
//     - MISALIGN_TRAP_EN undefined: returns mem[0x100].
//   - rst asserted in the second BUS cycle of an SW -> no RspVld; outputs 0 next cycle; ReqRdy=1.

Source files
------------

// File: rtl/lsu_mem_if.sv
// Load/store bridge: core byte-addressed access port to word-addressed RRdy/RVld memory bus.
// Latency: accept -> RspVld in 3 cycles minimum (accept, BUS x2, RESP); error requests respond 1 cycle after accept.
// Backpressure: one request in flight; ReqRdy is high only in IDLE, the core holds ReqVld until accepted.
//
// Ports:
//   clk/rst           clock, synchronous active-high reset
//   ReqVld/ReqRdy     core request handshake; ReqWr/ReqSize/ReqAddr/ReqWData request fields
//   RspVld/RspData/RspErr   one-cycle response pulse with extended load data or error flag
//   RRdy/RVld         memory request strobe / acknowledge (RData valid with RVld)
//   RAddr/RWData/RWEn/RWStrobe   word address, lane-replicated store data, write pulse, byte enables
// Build option: define MISALIGN_TRAP_EN to turn misaligned H/W accesses into error responses;
// otherwise the offending low address bits are forced to zero and the access completes.

module lsu_mem_if #(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ReqVld,
    output logic        ReqRdy,
    input  logic        ReqWr,
    input  logic [2:0]  ReqSize,
    input  logic [31:0] ReqAddr,
    input  logic [31:0] ReqWData,
    output logic        RspVld,
    output logic [31:0] RspData,
    output logic        RspErr,
    output logic        RRdy,
    input  logic        RVld,
    output logic [31:0] RAddr,
    output logic [31:0] RWData,
    output logic        RWEn,
    output logic [3:0]  RWStrobe,
    input  logic [31:0] RData
);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               wr_q;
    logic [2:0]         size_q;
    logic [1:0]         off_q;      // effective byte offset used to align load data
    logic               rrdy_q, rwen_q, rspvld_q, rsperr_q;
    logic [31:0]        raddr_q, rwdata_q, rspdata_q;
    logic [3:0]         rwstrb_q;

    // Request decode, evaluated on the incoming request fields
    logic               size_ok, req_err;
    logic [1:0]         eff_off;
    logic [3:0]         acc_strb;
    logic [31:0]        acc_wdat;
`ifdef MISALIGN_TRAP_EN
    logic               misalign;
`endif

    always_comb begin
        size_ok  = 1'b0;
        req_err  = 1'b0;
        eff_off  = 2'b00;
        acc_strb = 4'h0;
        acc_wdat = 32'h0;
`ifdef MISALIGN_TRAP_EN
        misalign = 1'b0;
`endif
        case (ReqSize)
            3'b000, 3'b001, 3'b010: size_ok = 1'b1;
            3'b100, 3'b101:         size_ok = !ReqWr;   // unsigned variants exist for loads only
            default:                size_ok = 1'b0;
        endcase
`ifdef MISALIGN_TRAP_EN
        misalign = ((ReqSize[1:0] == 2'b01) && ReqAddr[0]) ||
                   ((ReqSize[1:0] == 2'b10) && (ReqAddr[1:0] != 2'b00));
        req_err  = !size_ok || misalign;
`else
        req_err  = !size_ok;
`endif
        // Halfwords snap to A[1]; words ignore the low bits entirely
        case (ReqSize[1:0])
            2'b00: begin
                eff_off  = ReqAddr[1:0];
                acc_strb = 4'b0001 << eff_off;
                acc_wdat = {4{ReqWData[7:0]}};
            end
            2'b01: begin
                eff_off  = {ReqAddr[1], 1'b0};
                acc_strb = 4'b0011 << eff_off;
                acc_wdat = {2{ReqWData[15:0]}};
            end
            default: begin
                eff_off  = 2'b00;
                acc_strb = 4'hF;
                acc_wdat = ReqWData;
            end
        endcase
    end

    // Load data alignment and extension from the captured request size
    logic [31:0] ld_sh, ld_ext;
    always_comb begin
        ld_sh = RData >> {off_q, 3'b000};
        case (size_q)
            3'b000:  ld_ext = {{24{ld_sh[7]}}, ld_sh[7:0]};
            3'b001:  ld_ext = {{16{ld_sh[15]}}, ld_sh[15:0]};
            3'b100:  ld_ext = {24'h0, ld_sh[7:0]};
            3'b101:  ld_ext = {16'h0, ld_sh[15:0]};
            default: ld_ext = ld_sh;
        endcase
    end

    logic timeout_hit, rvld_ok;
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    assign rvld_ok     = RVld && (cnt_q != '0);    // acknowledge in the first BUS cycle is ignored

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            wr_q      <= 1'b0;
            size_q    <= 3'b000;
            off_q     <= 2'b00;
            rrdy_q    <= 1'b0;
            rwen_q    <= 1'b0;
            rspvld_q  <= 1'b0;
            rsperr_q  <= 1'b0;
            raddr_q   <= 32'h0;
            rwdata_q  <= 32'h0;
            rspdata_q <= 32'h0;
            rwstrb_q  <= 4'h0;
        end else begin
            rwen_q   <= 1'b0;
            rspvld_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ReqVld) begin
                        wr_q   <= ReqWr;
                        size_q <= ReqSize;
                        off_q  <= eff_off;
                        if (req_err) begin
                            state_q   <= S_RESP;
                            rspvld_q  <= 1'b1;
                            rsperr_q  <= 1'b1;
                            rspdata_q <= 32'h0;
                        end else begin
                            state_q  <= S_BUS;
                            cnt_q    <= '0;
                            rrdy_q   <= 1'b1;
                            rwen_q   <= ReqWr;
                            raddr_q  <= {2'b00, ReqAddr[31:2]};
                            rwdata_q <= ReqWr ? acc_wdat : 32'h0;
                            rwstrb_q <= ReqWr ? acc_strb : 4'h0;
                        end
                    end
                end
                S_BUS: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (rvld_ok || timeout_hit) begin
                        state_q   <= S_RESP;
                        rrdy_q    <= 1'b0;
                        raddr_q   <= 32'h0;
                        rwdata_q  <= 32'h0;
                        rwstrb_q  <= 4'h0;
                        rspvld_q  <= 1'b1;
                        rsperr_q  <= !rvld_ok;
                        rspdata_q <= (rvld_ok && !wr_q) ? ld_ext : 32'h0;
                    end
                end
                S_RESP: begin
                    state_q   <= S_IDLE;
                    rsperr_q  <= 1'b0;
                    rspdata_q <= 32'h0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ReqRdy   = (state_q == S_IDLE);
    assign RspVld   = rspvld_q;
    assign RspData  = rspdata_q;
    assign RspErr   = rsperr_q;
    assign RRdy     = rrdy_q;
    assign RAddr    = raddr_q;
    assign RWData   = rwdata_q;
    assign RWEn     = rwen_q;
    assign RWStrobe = rwstrb_q;

endmodule
